// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: reads a source word, writes it to the destination,
// and repeats until length words are moved, then pulses done.
module mem_copy_engine #(
   parameter int AW     = 16,
   parameter int DW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [15:0]   length,
   output logic          busy,
   output logic          done,
   output logic [15:0]   words_copied,
   output logic          MemRead,
   output logic          MemWrite,
   output logic [AW-1:0] address,
   output logic [DW-1:0] data_to_write,
   input  logic [DW-1:0] readed_data
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

   state_t        state;
   logic [AW-1:0] src_q;
   logic [AW-1:0] dst_q;
   logic [15:0]   len_q;
   logic [15:0]   index_q;
   logic [15:0]   index_next;
   logic [DW-1:0] buffer_q;
   logic [2:0]    lat_cnt;

   assign index_next    = index_q + 16'd1;
   assign busy          = (state != IDLE);
   assign data_to_write = (state == WRITE) ? buffer_q : '0;

   // Control outputs are registered: each transition loads the values the next state drives.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         index_q      <= '0;
         buffer_q     <= '0;
         lat_cnt      <= '0;
         words_copied <= '0;
         done         <= 1'b0;
         MemRead      <= 1'b0;
         MemWrite     <= 1'b0;
         address      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  src_q        <= src_addr;
                  dst_q        <= dst_addr;
                  len_q        <= length;
                  index_q      <= '0;
                  words_copied <= '0;
                  lat_cnt      <= '0;
                  if (length == 16'd0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state   <= READ;
                     MemRead <= 1'b1;
                     address <= src_addr;
                  end
               end
            end
            READ: begin
               if (abort) begin
                  state   <= IDLE;
                  MemRead <= 1'b0;
                  address <= '0;
               end else if (lat_cnt == LAT_LAST) begin
                  buffer_q <= readed_data;
                  lat_cnt  <= '0;
                  state    <= WRITE;
                  MemRead  <= 1'b0;
                  MemWrite <= 1'b1;
                  address  <= dst_q + AW'(index_q);
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            WRITE: begin
               MemWrite <= 1'b0;
               if (abort) begin
                  state   <= IDLE;
                  address <= '0;
               end else begin
                  index_q      <= index_next;
                  words_copied <= words_copied + 16'd1;
                  if (index_next == len_q) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     address <= '0;
                  end else begin
                     state   <= READ;
                     MemRead <= 1'b1;
                     address <= src_q + AW'(index_next);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: table of copy jobs plus abort, idle-abort
// and mid-copy reset sequences against a simple word memory model.
module tb_mem_copy_engine;

   typedef struct {
      string       name;
      logic [15:0] src;
      logic [15:0] dst;
      logic [15:0] len;
      logic [15:0] init [4];
      logic [15:0] expDst [4];
      int          expCycles;
      logic [15:0] expWords;
   } copyVec_t;

   logic        clock;
   logic        resetN;
   logic        start;
   logic        abort;
   logic [15:0] srcAddr;
   logic [15:0] dstAddr;
   logic [15:0] length;
   logic        busy;
   logic        done;
   logic [15:0] wordsCopied;
   logic        memRead;
   logic        memWrite;
   logic [15:0] address;
   logic [15:0] dataToWrite;
   logic [15:0] readedData;

   logic [15:0] mem [0:65535];
   logic        pokeEn;
   logic [15:0] pokeAddr;
   logic [15:0] pokeData;
   int          writeCount;
   int          bothHighCount;

   int checks;
   int failures;

   copyVec_t vecs [5];

   mem_copy_engine #(.AW(16), .DW(16), .RD_LAT(1)) dut (
      .clock(clock),
      .reset_n(resetN),
      .start(start),
      .abort(abort),
      .src_addr(srcAddr),
      .dst_addr(dstAddr),
      .length(length),
      .busy(busy),
      .done(done),
      .words_copied(wordsCopied),
      .MemRead(memRead),
      .MemWrite(memWrite),
      .address(address),
      .data_to_write(dataToWrite),
      .readed_data(readedData)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Zero-latency data memory; reads are combinational, writes land on the clock edge.
   assign readedData = mem[address];

   initial begin
      writeCount    = 0;
      bothHighCount = 0;
   end

   always @(posedge clock) begin
      if (pokeEn) mem[pokeAddr] <= pokeData;
      else if (memWrite) begin
         mem[address] <= dataToWrite;
         writeCount   <= writeCount + 1;
      end
      if (memRead && memWrite) bothHighCount <= bothHighCount + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic pokeMem(input logic [15:0] addr, input logic [15:0] data);
      @(negedge clock);
      pokeAddr = addr;
      pokeData = data;
      pokeEn   = 1'b1;
      @(negedge clock);
      pokeEn   = 1'b0;
   endtask

   task automatic applyStimulus(input int idx);
      int          cycles;
      int          startWrites;
      int          startBoth;
      logic        firstRead;
      logic [15:0] firstAddr;
      logic [15:0] a;
      for (int i = 0; i < 32'(vecs[idx].len); i++) begin
         a = vecs[idx].src + 16'(i);
         pokeMem(a, vecs[idx].init[i]);
      end
      startWrites = writeCount;
      startBoth   = bothHighCount;
      @(negedge clock);
      srcAddr = vecs[idx].src;
      dstAddr = vecs[idx].dst;
      length  = vecs[idx].len;
      start   = 1'b1;
      @(negedge clock);
      start     = 1'b0;
      cycles    = 1;
      firstRead = memRead;
      firstAddr = address;
      while (!done && cycles < 200) begin
         @(negedge clock);
         cycles++;
      end
      checkOutput({vecs[idx].name, "_done"}, 32'(done), 32'd1);
      checkOutput({vecs[idx].name, "_cycles"}, 32'(cycles), 32'(vecs[idx].expCycles));
      checkOutput({vecs[idx].name, "_words"}, 32'(wordsCopied), 32'(vecs[idx].expWords));
      if (vecs[idx].len != 16'd0) begin
         checkOutput({vecs[idx].name, "_firstRead"}, 32'(firstRead), 32'd1);
         checkOutput({vecs[idx].name, "_firstAddr"}, 32'(firstAddr), 32'(vecs[idx].src));
      end else begin
         checkOutput({vecs[idx].name, "_noRead"}, 32'(firstRead), 32'd0);
      end
      @(negedge clock);
      checkOutput({vecs[idx].name, "_busyAfter"}, 32'(busy), 32'd0);
      checkOutput({vecs[idx].name, "_donePulse"}, 32'(done), 32'd0);
      checkOutput({vecs[idx].name, "_wordsHeld"}, 32'(wordsCopied), 32'(vecs[idx].expWords));
      checkOutput({vecs[idx].name, "_writes"}, 32'(writeCount - startWrites), 32'(vecs[idx].len));
      checkOutput({vecs[idx].name, "_bothHigh"}, 32'(bothHighCount - startBoth), 32'd0);
      for (int i = 0; i < 32'(vecs[idx].len); i++) begin
         a = vecs[idx].dst + 16'(i);
         checkOutput({vecs[idx].name, "_dst"}, 32'(mem[a]), 32'(vecs[idx].expDst[i]));
      end
   endtask

   initial begin
      int cnt;
      int wcSnap;
      logic sawDone;
      checks   = 0;
      failures = 0;
      pokeEn   = 1'b0;
      pokeAddr = '0;
      pokeData = '0;
      start    = 1'b0;
      abort    = 1'b0;
      srcAddr  = '0;
      dstAddr  = '0;
      length   = '0;
      resetN   = 1'b1;

      vecs[0] = '{name: "single",  src: 16'h1111, dst: 16'h2000, len: 16'd1,
                  init: '{16'd1, 16'd0, 16'd0, 16'd0}, expDst: '{16'd1, 16'd0, 16'd0, 16'd0},
                  expCycles: 3, expWords: 16'd1};
      vecs[1] = '{name: "four",    src: 16'h0010, dst: 16'h0100, len: 16'd4,
                  init: '{16'd5, 16'd6, 16'd7, 16'd8}, expDst: '{16'd5, 16'd6, 16'd7, 16'd8},
                  expCycles: 9, expWords: 16'd4};
      vecs[2] = '{name: "zero",    src: 16'h3000, dst: 16'h4000, len: 16'd0,
                  init: '{16'd0, 16'd0, 16'd0, 16'd0}, expDst: '{16'd0, 16'd0, 16'd0, 16'd0},
                  expCycles: 1, expWords: 16'd0};
      vecs[3] = '{name: "wrap",    src: 16'h0000, dst: 16'hFFFF, len: 16'd2,
                  init: '{16'hAAAA, 16'h5555, 16'd0, 16'd0}, expDst: '{16'hAAAA, 16'h5555, 16'd0, 16'd0},
                  expCycles: 5, expWords: 16'd2};
      vecs[4] = '{name: "overlap", src: 16'h0500, dst: 16'h0501, len: 16'd3,
                  init: '{16'd1, 16'd2, 16'd3, 16'd0}, expDst: '{16'd1, 16'd1, 16'd1, 16'd0},
                  expCycles: 7, expWords: 16'd3};

      #2 resetN = 1'b0;
      #1;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_memRead", 32'(memRead), 32'd0);
      checkOutput("rst_memWrite", 32'(memWrite), 32'd0);
      checkOutput("rst_address", 32'(address), 32'd0);
      checkOutput("rst_data", 32'(dataToWrite), 32'd0);
      checkOutput("rst_words", 32'(wordsCopied), 32'd0);
      @(negedge clock);
      @(negedge clock);
      resetN = 1'b1;

      for (int v = 0; v < 5; v++) applyStimulus(v);

      // Abort on the third write, with a start pulse thrown in while busy.
      for (int i = 0; i < 8; i++) pokeMem(16'h0600 + 16'(i), 16'h0100 + 16'(i));
      pokeMem(16'h0703, 16'h0000);
      @(negedge clock);
      srcAddr = 16'h0600;
      dstAddr = 16'h0700;
      length  = 16'd8;
      start   = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      srcAddr = 16'h0F00;
      length  = 16'd1;
      start   = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checkOutput("abort_ignoredStartWrite", 32'(memWrite), 32'd1);
      checkOutput("abort_ignoredStartAddr", 32'(address), 32'h0701);
      @(negedge clock);
      @(negedge clock);
      checkOutput("abort_thirdWrite", 32'(memWrite), 32'd1);
      checkOutput("abort_thirdAddr", 32'(address), 32'h0702);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      start = 1'b0;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_words", 32'(wordsCopied), 32'd2);
      checkOutput("abort_memWrite", 32'(memWrite), 32'd0);
      checkOutput("abort_address", 32'(address), 32'd0);
      sawDone = done;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         sawDone = sawDone | done;
      end
      checkOutput("abort_noDone", 32'(sawDone), 32'd0);
      checkOutput("abort_wordsHeld", 32'(wordsCopied), 32'd2);
      checkOutput("abort_noFourthWrite", 32'(mem[16'h0703]), 32'd0);

      // Abort while idle must not block a start in the same cycle.
      pokeMem(16'h2100, 16'h0000);
      @(negedge clock);
      srcAddr = 16'h1111;
      dstAddr = 16'h2100;
      length  = 16'd1;
      start   = 1'b1;
      abort   = 1'b1;
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      checkOutput("idleAbort_busy", 32'(busy), 32'd1);
      cnt = 0;
      while (!done && cnt < 20) begin
         @(negedge clock);
         cnt++;
      end
      checkOutput("idleAbort_done", 32'(done), 32'd1);
      @(negedge clock);
      checkOutput("idleAbort_data", 32'(mem[16'h2100]), 32'd1);

      // Reset asserted in the middle of a READ.
      for (int i = 0; i < 4; i++) pokeMem(16'h0800 + 16'(i), 16'h0C00 + 16'(i));
      pokeMem(16'h0901, 16'h0000);
      @(negedge clock);
      srcAddr = 16'h0800;
      dstAddr = 16'h0900;
      length  = 16'd4;
      start   = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checkOutput("midRst_inRead", 32'(memRead), 32'd1);
      resetN = 1'b0;
      #1;
      checkOutput("midRst_memRead", 32'(memRead), 32'd0);
      checkOutput("midRst_memWrite", 32'(memWrite), 32'd0);
      checkOutput("midRst_address", 32'(address), 32'd0);
      checkOutput("midRst_data", 32'(dataToWrite), 32'd0);
      checkOutput("midRst_busy", 32'(busy), 32'd0);
      checkOutput("midRst_words", 32'(wordsCopied), 32'd0);
      wcSnap = writeCount;
      @(negedge clock);
      resetN = 1'b1;
      repeat (6) @(negedge clock);
      checkOutput("midRst_noWrites", 32'(writeCount - wcSnap), 32'd0);
      checkOutput("midRst_idle", 32'(busy), 32'd0);
      checkOutput("midRst_dstUntouched", 32'(mem[16'h0901]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
